victory_scorer: RTL and testbench
=================================

Name: victory_scorer

Overview:
- Parametrised match-level victory block for the two-player tug-of-war game.
- Detects round wins from the playfield end LEDs and the L/R button inputs, and keeps per-player round scores.
- Issues a one-cycle round_over pulse so the playfield re-centres, and declares a match champion once a player reaches WIN_ROUNDS.
- Drives two active-low 7-segment digits with the scores; sits between the playfield LED logic and the HEX displays.

Parameters:
- WIN_ROUNDS, 3: rounds needed to win the match; legal range 1..9.
- HOLD_CYCLES, 4: cycles spent in ROUND_END, with inputs ignored, before play resumes; legal range 1..255.
- SCORE_W, 4: score counter width; must satisfy 2^SCORE_W > WIN_ROUNDS.

Ports:
- clk  input  1  system clock, all logic on posedge.
- reset  input  1  synchronous, active-low reset; reset==0 at a posedge resets the block.
- L  input  1  left button, already synchronised and one-cycle pulsed.
- R  input  1  right button, already synchronised and one-cycle pulsed.
- led_left  input  1  leftmost playfield LED lit.
- led_right  input  1  rightmost playfield LED lit.
- round_over  output  1  one-cycle pulse, registered; playfield re-centres on it.
- match_over  output  1  high while in MATCH_OVER.
- champion  output  2  00 none, 01 player one, 10 player two.
- hex_p1  output  7  active-low 7-seg digit for score_p1.
- hex_p2  output  7  active-low 7-seg digit for score_p2.

Behaviour:
- Reset (reset==0 at posedge):
  - state=PLAY, score_p1=score_p2=0, hold counter=0.
  - round_over=0, match_over=0, champion=00.
  - hex_p1=hex_p2=1000000 (digit 0).
  - Reset has priority over every other event, including mid-hold and in MATCH_OVER.
- Win conditions, sampled only in PLAY:
  - p1_win = led_right & R & ~L.
  - p2_win = led_left & L & ~R.
  - L and R together, or no lit end LED, is not a win.
  - p1_win and p2_win both true in the same cycle cannot occur (they are mutually exclusive); no special case is required.
- PLAY:
  - On a posedge with p1_win, score_p1 increments. If the new score_p1==WIN_ROUNDS, go to MATCH_OVER with champion=01; otherwise go to ROUND_END with hold counter=0.
  - p2_win is symmetric, giving champion=10.
  - round_over=1 in the cycle after a win edge, for exactly one cycle, whichever of ROUND_END or MATCH_OVER is entered.
- ROUND_END:
  - All inputs are ignored.
  - The hold counter increments each cycle; after HOLD_CYCLES cycles in ROUND_END, return to PLAY.
  - A win condition held through the whole hold window scores once only, on the first PLAY cycle after the hold.
- MATCH_OVER:
  - Terminal state: match_over=1, champion held, scores frozen, round_over=0.
  - Exits only on reset.
- Score latency: hex outputs are registered and reflect the new score in the cycle after the win edge, the same cycle round_over is high.
- Scores never exceed WIN_ROUNDS, so there is no wrap-around.
- 7-seg encoding, gfedcba, active-low:
  - 0=1000000, 1=1111001, 2=0100100, 3=0110000, 4=0011001.
  - 5=0010010, 6=0000010, 7=1111000, 8=0000000, 9=0010000.
  - Any other value is 1111111 (blank).
- Unused state encodings recover to PLAY on the next posedge, with outputs as in PLAY.

Test Plan:
- Reset, then idle 5 cycles with all inputs 0 -> state PLAY; hex_p1=hex_p2=1000000; round_over=0; champion=00.
- led_right=1, R=1, L=0 for 1 cycle -> next cycle round_over=1 and hex_p1=1111001; then exactly 4 cycles of ROUND_END, during which an L+led_left pulse is ignored (hex_p2 stays 1000000).
- led_left=1, L=1, R=1 for 1 cycle, and led_right=0, R=1 with led_right low -> no score change, no round_over.
- Player two wins 3 rounds, each separated by the hold -> after the third win: match_over=1, champion=10, hex_p2=0110000, round_over pulses once; further win stimulus leaves all outputs unchanged.
- Reset asserted (reset=0) during the second ROUND_END cycle -> the next cycle shows scores 0, state PLAY, round_over=0; and from MATCH_OVER, reset clears champion to 00.
- With WIN_ROUNDS=1 and HOLD_CYCLES=1: a single p1_win -> MATCH_OVER directly, champion=01, hex_p1=1111001, and ROUND_END is never entered.

Source files
------------

// File: rtl/victory_scorer.sv
// Tug-of-war match scorer: detects round wins, keeps scores, drives score digits, latches the champion.
// Latency: round_over, hex digits and match_over/champion are registered, one cycle after the win edge.
// Backpressure: none; inputs are ignored outside PLAY, and the block sits terminal in MATCH_OVER until reset.
module victory_scorer #(
    parameter int WIN_ROUNDS  = 3,
    parameter int HOLD_CYCLES = 4,
    parameter int SCORE_W     = 4
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       L,
    input  logic       R,
    input  logic       led_left,
    input  logic       led_right,
    output logic       round_over,
    output logic       match_over,
    output logic [1:0] champion,
    output logic [6:0] hex_p1,
    output logic [6:0] hex_p2
);

    typedef enum logic [1:0] {
        PLAY       = 2'd0,
        ROUND_END  = 2'd1,
        MATCH_OVER = 2'd2
    } state_t;

    localparam logic [SCORE_W-1:0] WIN_VAL   = SCORE_W'(WIN_ROUNDS);
    localparam logic [7:0]         HOLD_LAST = 8'(HOLD_CYCLES - 1);
    localparam logic [6:0]         SEG_ZERO  = 7'b1000000;

    state_t             state;
    logic [SCORE_W-1:0] score_p1;
    logic [SCORE_W-1:0] score_p2;
    logic [7:0]         hold_cnt;

    logic               p1_win;
    logic               p2_win;
    logic [SCORE_W-1:0] p1_next;
    logic [SCORE_W-1:0] p2_next;

    assign p1_win  = led_right & R & ~L;
    assign p2_win  = led_left & L & ~R;
    assign p1_next = score_p1 + 1'b1;
    assign p2_next = score_p2 + 1'b1;

    // Active-low gfedcba; anything outside 0..9 blanks the digit.
    function automatic logic [6:0] seg7(input logic [SCORE_W-1:0] v);
        int unsigned iv;
        iv = 32'(v);
        case (iv)
            0:       seg7 = 7'b1000000;
            1:       seg7 = 7'b1111001;
            2:       seg7 = 7'b0100100;
            3:       seg7 = 7'b0110000;
            4:       seg7 = 7'b0011001;
            5:       seg7 = 7'b0010010;
            6:       seg7 = 7'b0000010;
            7:       seg7 = 7'b1111000;
            8:       seg7 = 7'b0000000;
            9:       seg7 = 7'b0010000;
            default: seg7 = 7'b1111111;
        endcase
    endfunction

    always_ff @(posedge clk) begin
        if (!reset) begin
            state      <= PLAY;
            score_p1   <= '0;
            score_p2   <= '0;
            hold_cnt   <= '0;
            round_over <= 1'b0;
            match_over <= 1'b0;
            champion   <= 2'b00;
            hex_p1     <= SEG_ZERO;
            hex_p2     <= SEG_ZERO;
        end else begin
            case (state)
                PLAY: begin
                    round_over <= 1'b0;
                    if (p1_win) begin
                        score_p1   <= p1_next;
                        hex_p1     <= seg7(p1_next);
                        round_over <= 1'b1;
                        hold_cnt   <= '0;
                        if (p1_next == WIN_VAL) begin
                            state      <= MATCH_OVER;
                            match_over <= 1'b1;
                            champion   <= 2'b01;
                        end else begin
                            state <= ROUND_END;
                        end
                    end else if (p2_win) begin
                        score_p2   <= p2_next;
                        hex_p2     <= seg7(p2_next);
                        round_over <= 1'b1;
                        hold_cnt   <= '0;
                        if (p2_next == WIN_VAL) begin
                            state      <= MATCH_OVER;
                            match_over <= 1'b1;
                            champion   <= 2'b10;
                        end else begin
                            state <= ROUND_END;
                        end
                    end
                end
                ROUND_END: begin
                    round_over <= 1'b0;
                    // Last hold cycle hands back to PLAY, so the window is exactly HOLD_CYCLES long.
                    if (hold_cnt == HOLD_LAST) begin
                        state    <= PLAY;
                        hold_cnt <= '0;
                    end else begin
                        hold_cnt <= hold_cnt + 8'd1;
                    end
                end
                MATCH_OVER: begin
                    round_over <= 1'b0;
                    match_over <= 1'b1;
                end
                default: begin
                    state      <= PLAY;
                    hold_cnt   <= '0;
                    round_over <= 1'b0;
                    match_over <= 1'b0;
                    champion   <= 2'b00;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_victory_scorer.sv
// Directed plus random bench for victory_scorer: two instances (3 rounds/hold 4, and 1 round/hold 1) share stimulus
// and are compared every cycle against a round/score reference model.
module tb_victory_scorer;

    logic clk = 1'b0;
    logic reset = 1'b0;
    logic L = 1'b0, R = 1'b0, led_left = 1'b0, led_right = 1'b0;

    logic       ro [2];
    logic       mo [2];
    logic [1:0] ch [2];
    logic [6:0] h1 [2];
    logic [6:0] h2 [2];

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    victory_scorer #(.WIN_ROUNDS(3), .HOLD_CYCLES(4), .SCORE_W(4)) dut_a (
        .clk(clk), .reset(reset), .L(L), .R(R), .led_left(led_left), .led_right(led_right),
        .round_over(ro[0]), .match_over(mo[0]), .champion(ch[0]), .hex_p1(h1[0]), .hex_p2(h2[0])
    );

    victory_scorer #(.WIN_ROUNDS(1), .HOLD_CYCLES(1), .SCORE_W(2)) dut_b (
        .clk(clk), .reset(reset), .L(L), .R(R), .led_left(led_left), .led_right(led_right),
        .round_over(ro[1]), .match_over(mo[1]), .champion(ch[1]), .hex_p1(h1[1]), .hex_p2(h2[1])
    );

    // Reference model: mode 0 = playing, 1 = between rounds, 2 = match decided.
    int win_rounds [2] = '{3, 1};
    int hold_len   [2] = '{4, 1};
    int mode       [2];
    int hold_left  [2];
    int s1         [2];
    int s2         [2];
    int champ      [2];
    int pulse      [2];
    int hold_seen  [2];

    logic [6:0] segtab [0:9] = '{7'b1000000, 7'b1111001, 7'b0100100, 7'b0110000, 7'b0011001,
                                 7'b0010010, 7'b0000010, 7'b1111000, 7'b0000000, 7'b0010000};

    task automatic model_edge();
        bit p1, p2;
        p1 = led_right && R && !L;
        p2 = led_left && L && !R;
        for (int k = 0; k < 2; k++) begin
            pulse[k] = 0;
            if (!reset) begin
                mode[k] = 0; s1[k] = 0; s2[k] = 0; champ[k] = 0; hold_left[k] = 0;
            end else if (mode[k] == 0) begin
                if (p1 || p2) begin
                    pulse[k] = 1;
                    if (p1) s1[k]++; else s2[k]++;
                    if (s1[k] == win_rounds[k] || s2[k] == win_rounds[k]) begin
                        mode[k]  = 2;
                        champ[k] = p1 ? 1 : 2;
                    end else begin
                        mode[k]      = 1;
                        hold_left[k] = hold_len[k];
                        hold_seen[k]++;
                    end
                end
            end else if (mode[k] == 1) begin
                hold_left[k]--;
                if (hold_left[k] == 0) mode[k] = 0;
            end
        end
    endtask

    task automatic check(input string tag, input logic [6:0] obs, input logic [6:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%b expected=%b", tag, obs, exp);
        end
    endtask

    task automatic step(input logic rst, input logic l, input logic r, input logic ll, input logic lr);
        reset = rst; L = l; R = r; led_left = ll; led_right = lr;
        @(posedge clk);
        model_edge();
        #1;
        for (int k = 0; k < 2; k++) begin
            check($sformatf("round_over[%0d]", k), {6'd0, ro[k]}, {6'd0, pulse[k] == 1});
            check($sformatf("match_over[%0d]", k), {6'd0, mo[k]}, {6'd0, mode[k] == 2});
            check($sformatf("champion[%0d]", k), {5'd0, ch[k]}, 7'(champ[k]));
            check($sformatf("hex_p1[%0d]", k), h1[k], segtab[s1[k]]);
            check($sformatf("hex_p2[%0d]", k), h2[k], segtab[s2[k]]);
        end
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) step(1, 0, 0, 0, 0);
    endtask

    initial begin
        for (int k = 0; k < 2; k++) begin
            mode[k] = 0; hold_left[k] = 0; s1[k] = 0; s2[k] = 0; champ[k] = 0; pulse[k] = 0; hold_seen[k] = 0;
        end
        // Reset and idle
        step(0, 0, 0, 0, 0);
        step(0, 0, 0, 0, 0);
        idle(5);
        check("reset_hex_p1_digit0", h1[0], 7'b1000000);

        // Player one wins a round; player two's attempt during the hold is ignored
        step(1, 0, 1, 0, 1);
        check("p1_first_win_hex", h1[0], 7'b1111001);
        step(1, 1, 0, 1, 0);
        idle(3);
        check("hold_ignored_hex_p2", h2[0], 7'b1000000);

        // Non-wins: both buttons, and button without lit end LED
        step(1, 1, 1, 1, 0);
        step(1, 0, 1, 0, 0);
        step(1, 1, 0, 0, 0);
        idle(1);

        // Player two takes three rounds
        for (int w = 0; w < 3; w++) begin
            step(1, 1, 0, 1, 0);
            idle(4);
        end
        check("p2_match_hex_p2", h2[0], 7'b0110000);
        check("p2_match_champion", {5'd0, ch[0]}, 7'b0000010);
        step(1, 0, 1, 0, 1);
        step(1, 1, 0, 1, 0);
        idle(2);

        // Reset out of the decided match
        step(0, 0, 0, 0, 0);
        check("reset_clears_champion", {5'd0, ch[0]}, 7'b0000000);
        idle(2);

        // Reset during the second hold cycle
        step(1, 0, 1, 0, 1);
        idle(1);
        step(0, 0, 0, 0, 0);
        check("midhold_reset_hex_p1", h1[0], 7'b1000000);
        idle(2);

        // Win condition held through the whole hold window scores once after it
        step(1, 1, 0, 1, 0);
        for (int i = 0; i < 6; i++) step(1, 1, 0, 1, 0);
        idle(4);
        step(0, 0, 0, 0, 0);

        // Random phase with biased wins and occasional resets
        for (int i = 0; i < 600; i++) begin
            logic rr, bl, br, bll, blr;
            int sel;
            rr  = ($urandom_range(0, 49) != 0);
            sel = $urandom_range(0, 3);
            if (sel == 0) begin
                bl = 0; br = 1; bll = 1'($urandom_range(0, 1)); blr = 1;
            end else if (sel == 1) begin
                bl = 1; br = 0; bll = 1; blr = 1'($urandom_range(0, 1));
            end else begin
                bl = 1'($urandom_range(0, 1)); br = 1'($urandom_range(0, 1));
                bll = 1'($urandom_range(0, 1)); blr = 1'($urandom_range(0, 1));
            end
            step(rr, bl, br, bll, blr);
        end

        // The single-round instance must never have entered a hold window
        total++;
        assert (hold_seen[1] == 0 && hold_seen[0] > 0) else begin
            bad++;
            $error("FAIL hold_usage observed=%0d/%0d expected=0/>0", hold_seen[1], hold_seen[0]);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
